aibcr3pnr_dll_rst_seq: RTL and testbench



---
 rtl/aibcr3pnr_dll_rst_seq.sv | 119 +++++++++++
 tb/tb_aibcr3pnr_dll_rst_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aibcr3pnr_dll_rst_seq.sv
// Multi-channel DLL reset sequencer: qualifies, synchronises and holds each channel's
// reset, then releases channels in a staggered order to limit start-up current.
module aibcr3pnr_dll_rst_seq #(
    parameter int unsigned NCH         = 4,
    parameter int unsigned CW          = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STAGGER     = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           reinit,
    input  logic           entest,
    input  logic [NCH-1:0] ndllrst_in,
    input  logic [NCH-1:0] rb_dll_en,
    input  logic [NCH-1:0] rb_dll_rst_en,
    input  logic [CW-1:0]  rb_hold_cnt,
    input  logic           atpg_en_n,
    input  logic           test_clr_n,
    output logic [NCH-1:0] dll_reset_n,
    output logic           dll_rst_busy
);

    localparam int unsigned SW = $clog2(STAGGER + 1);

    typedef enum logic [1:0] {
        StRst,
        StHold,
        StRel
    } state_e;

    logic [NCH-1:0] en_raw;
    logic [NCH-1:0] clr_n;
    logic [NCH-1:0] tok_ok;
    logic [NCH-1:0] stag_done;
    logic [NCH-1:0] in_hold;
    logic [NCH-1:0] in_rel;
    logic           busy_q;

    always_comb begin
        en_raw = ~{NCH{entest}} & rb_dll_en & ~{NCH{reinit}} & ~(rb_dll_rst_en & ~ndllrst_in);
        clr_n  = atpg_en_n ? ({NCH{rst_n}} & en_raw) : {NCH{test_clr_n}};
    end

    // A disabled predecessor passes the token straight through so the chain cannot deadlock.
    always_comb begin
        tok_ok = '1;
        for (int i = 1; i < NCH; i++) begin
            tok_ok[i] = ~rb_dll_en[i-1] | stag_done[i-1];
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic                   ch_clr_n;
        logic [SYNC_STAGES-1:0] sync_q;
        state_e                 state_q, state_d;
        logic [CW-1:0]          cnt_q, cnt_d;
        logic [SW-1:0]          stag_q, stag_d;

        assign ch_clr_n = clr_n[g];

        always_ff @(posedge clk or negedge ch_clr_n) begin
            if (!ch_clr_n) begin
                sync_q  <= '0;
                state_q <= StRst;
                cnt_q   <= '0;
                stag_q  <= '0;
            end else begin
                sync_q  <= {sync_q[SYNC_STAGES-2:0], 1'b1};
                state_q <= state_d;
                cnt_q   <= cnt_d;
                stag_q  <= stag_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            stag_d  = stag_q;
            case (state_q)
                StRst: begin
                    if (sync_q[SYNC_STAGES-1]) begin
                        state_d = StHold;
                        cnt_d   = rb_hold_cnt;
                    end
                end
                StHold: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else if (tok_ok[g]) begin
                        state_d = StRel;
                    end
                end
                StRel: begin
                    if (stag_q != SW'(STAGGER)) begin
                        stag_d = stag_q + SW'(1);
                    end
                end
                default: state_d = StRst;
            endcase
        end

        assign in_hold[g]   = (state_q == StHold);
        assign in_rel[g]    = (state_q == StRel);
        assign stag_done[g] = (stag_q == SW'(STAGGER));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= |in_hold;
        end
    end

    assign dll_rst_busy = busy_q;
    // Scan mode hands the reset straight to the tester; the FSM keeps running underneath.
    assign dll_reset_n  = atpg_en_n ? in_rel : {NCH{test_clr_n & rst_n}};

endmodule

// File: tb/tb_aibcr3pnr_dll_rst_seq.sv
// Bench for aibcr3pnr_dll_rst_seq: age-based per-channel model checked every cycle,
// plus directed release-edge expectations.
module tb_aibcr3pnr_dll_rst_seq;

    localparam int NCH  = 4;
    localparam int CW   = 8;
    localparam int SYNC = 2;
    localparam int STAG = 4;

    logic           clk;
    logic           rst_n;
    logic           reinit;
    logic           entest;
    logic [NCH-1:0] ndllrst_in;
    logic [NCH-1:0] rb_dll_en;
    logic [NCH-1:0] rb_dll_rst_en;
    logic [CW-1:0]  rb_hold_cnt;
    logic           atpg_en_n;
    logic           test_clr_n;
    logic [NCH-1:0] dll_reset_n;
    logic           dll_rst_busy;

    aibcr3pnr_dll_rst_seq #(
        .NCH        (NCH),
        .CW         (CW),
        .SYNC_STAGES(SYNC),
        .STAGGER    (STAG)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .reinit       (reinit),
        .entest       (entest),
        .ndllrst_in   (ndllrst_in),
        .rb_dll_en    (rb_dll_en),
        .rb_dll_rst_en(rb_dll_rst_en),
        .rb_hold_cnt  (rb_hold_cnt),
        .atpg_en_n    (atpg_en_n),
        .test_clr_n   (test_clr_n),
        .dll_reset_n  (dll_reset_n),
        .dll_rst_busy (dll_rst_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: each channel tracks edges elapsed since its clear lifted and, once released,
    // edges elapsed since release.
    logic [NCH-1:0] m_clr_n;
    int             m_age     [NCH];
    int             m_hold    [NCH];
    int             m_rel_age [NCH];
    bit             m_holding [NCH];
    bit             m_rel     [NCH];
    bit             m_busy;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            m_clr_n[i] = atpg_en_n ? (rst_n && !entest && rb_dll_en[i] && !reinit &&
                                      !(rb_dll_rst_en[i] && !ndllrst_in[i])) : test_clr_n;
        end
    end

    task automatic m_clear(input int i);
        m_age[i]     = 0;
        m_hold[i]    = 0;
        m_rel_age[i] = 0;
        m_holding[i] = 1'b0;
        m_rel[i]     = 1'b0;
    endtask

    always @(m_clr_n) begin
        for (int i = 0; i < NCH; i++) if (!m_clr_n[i]) m_clear(i);
    end

    always @(negedge rst_n) m_busy = 1'b0;

    always @(posedge clk) begin
        bit tok [NCH];
        bit any_hold;
        any_hold = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            any_hold = any_hold | m_holding[i];
            if (i == 0) tok[i] = 1'b1;
            else tok[i] = !rb_dll_en[i-1] || (m_rel[i-1] && m_rel_age[i-1] >= STAG);
        end
        m_busy = rst_n ? any_hold : 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!m_clr_n[i]) begin
                m_clear(i);
            end else begin
                if (m_age[i] < 100000) m_age[i]++;
                if (m_rel[i]) begin
                    if (m_rel_age[i] < STAG) m_rel_age[i]++;
                end else if (m_holding[i]) begin
                    if (m_age[i] >= SYNC + 2 + m_hold[i] && tok[i]) begin
                        m_rel[i]     = 1'b1;
                        m_holding[i] = 1'b0;
                        m_rel_age[i] = 0;
                    end
                end else if (m_age[i] == SYNC + 1) begin
                    m_holding[i] = 1'b1;
                    m_hold[i]    = int'(rb_hold_cnt);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [NCH-1:0] m_vec;
        for (int i = 0; i < NCH; i++) m_vec[i] = atpg_en_n ? m_rel[i] : (test_clr_n && rst_n);
        check("model_dll_reset_n", int'(dll_reset_n), int'(m_vec));
        check("model_busy", int'(dll_rst_busy), int'(m_busy));
    end

    // Edge bookkeeping for the directed expectations.
    int edge_no = 0;
    int rise [NCH];
    int busy_first;
    int busy_last;

    always @(posedge clk) edge_no++;

    always @(negedge clk) begin
        for (int i = 0; i < NCH; i++) if (dll_reset_n[i] && rise[i] < 0) rise[i] = edge_no;
        if (dll_rst_busy) begin
            if (busy_first < 0) busy_first = edge_no;
            busy_last = edge_no;
        end
    end

    task automatic mark_start();
        edge_no = 0;
        for (int i = 0; i < NCH; i++) rise[i] = -1;
        busy_first = -1;
        busy_last  = -1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_rise(input string tag, input int e0, input int e1, input int e2,
                              input int e3);
        check({tag, "_rise0"}, rise[0], e0);
        check({tag, "_rise1"}, rise[1], e1);
        check({tag, "_rise2"}, rise[2], e2);
        check({tag, "_rise3"}, rise[3], e3);
    endtask

    task automatic restart();
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        mark_start();
    endtask

    initial begin
        rst_n         = 1'b0;
        reinit        = 1'b0;
        entest        = 1'b0;
        ndllrst_in    = '1;
        rb_dll_en     = '1;
        rb_dll_rst_en = '0;
        rb_hold_cnt   = 8'd3;
        atpg_en_n     = 1'b1;
        test_clr_n    = 1'b1;
        mark_start();

        step(2);
        check("reset_out", int'(dll_reset_n), 0);
        check("reset_busy", int'(dll_rst_busy), 0);

        // Full staggered sequence, hold 3.
        rst_n = 1'b1;
        mark_start();
        step(30);
        check_rise("seq", 7, 12, 17, 22);
        check("seq_busy_first", busy_first, 4);
        check("seq_busy_last", busy_last, 22);

        // Reinit pulse clears asynchronously; hold change mid-HOLD must not move timing.
        reinit = 1'b1;
        #1;
        check("reinit_async", int'(dll_reset_n), 0);
        reinit = 1'b0;
        mark_start();
        step(4);
        rb_hold_cnt = 8'd9;
        step(26);
        check_rise("reinit", 7, 12, 17, 22);
        check("reinit_busy_last", busy_last, 22);
        rb_hold_cnt = 8'd3;

        // Channel 2 disabled: channel 3 skips it.
        rb_dll_en = 4'b1011;
        restart();
        step(30);
        check_rise("en1011", 7, 12, -1, 7);
        rb_dll_en = 4'b1111;

        // Core reset on channel 1 mid-HOLD.
        rb_dll_rst_en = 4'b0010;
        restart();
        step(9);
        ndllrst_in[1] = 1'b0;
        step(1);
        ndllrst_in[1] = 1'b1;
        step(25);
        check_rise("ndll", 7, 17, 22, 27);
        check("ndll_busy_last", busy_last, 27);
        ndllrst_in[1] = 1'b0;
        #1;
        check("ndll_pred_drop", int'(dll_reset_n), 4'b1101);
        step(1);
        ndllrst_in[1] = 1'b1;
        step(12);
        check("ndll_re_release", int'(dll_reset_n), 4'b1111);
        rb_dll_rst_en = 4'b0000;

        // Hold count extremes, with an rst_n abort mid-HOLD.
        rb_hold_cnt = 8'd0;
        restart();
        step(10);
        check("hold0_rise0", rise[0], 4);
        rb_hold_cnt = 8'd255;
        restart();
        step(100);
        rst_n = 1'b0;
        #1;
        check("abort_out", int'(dll_reset_n), 0);
        check("abort_busy", int'(dll_rst_busy), 0);
        step(1);
        rst_n = 1'b1;
        mark_start();
        step(100);
        rb_hold_cnt = 8'd7;
        step(170);
        check("hold255_rise0", rise[0], 259);
        check("hold255_rise1", rise[1], 264);
        rb_hold_cnt = 8'd3;

        // Scan bypass: outputs follow test_clr_n between clock edges, en_raw ignored.
        entest    = 1'b1;
        reinit    = 1'b1;
        atpg_en_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            test_clr_n = (k % 2 == 1);
            #1;
            check("scan_follow", int'(dll_reset_n), (k % 2 == 1) ? 15 : 0);
        end
        test_clr_n = 1'b1;
        step(3);
        check("scan_hold_high", int'(dll_reset_n), 15);
        test_clr_n = 1'b0;
        step(2);
        check("scan_low", int'(dll_reset_n), 0);
        atpg_en_n  = 1'b1;
        entest     = 1'b0;
        reinit     = 1'b0;
        test_clr_n = 1'b1;
        mark_start();
        step(30);
        check_rise("post_scan", 7, 12, 17, 22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
